// File: rtl/lifm_column_packer.sv
// lifm_column_packer
//   Packs lowered-IFM words, one per in_valid/in_ready handshake, into LIFM columns of
//   STEP_RANGE words. Columns are grouped into frames of at most MAX_LIFM_RSIZ columns.
//   Finished columns wait in a FIFO_DEPTH-entry FIFO and are presented one per transfer.
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   in_valid/in_ready      input word handshake; in_word is the word, in_last closes the frame
//   out_ready              downstream accepts the head column
//   enable_out             head column valid
//   lifm_column            head column, word i at [i*WORD_WIDTH +: WORD_WIDTH]
//   col_idx, col_last      position of the head column within its frame
//   frames_done            frames fully transferred out, wraps mod 2^16
module lifm_column_packer #(
    parameter int unsigned WORD_WIDTH    = 8,
    parameter int unsigned STEP_RANGE    = 128,
    parameter int unsigned MAX_LIFM_RSIZ = 3,
    parameter int unsigned FIFO_DEPTH    = 2,
    localparam int unsigned CIDX_WIDTH   = $clog2(MAX_LIFM_RSIZ)
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WORD_WIDTH-1:0]            in_word,
    input  logic                             in_last,
    input  logic                             out_ready,
    output logic                             enable_out,
    output logic [WORD_WIDTH*STEP_RANGE-1:0] lifm_column,
    output logic [CIDX_WIDTH-1:0]            col_idx,
    output logic                             col_last,
    output logic [15:0]                      frames_done
);

    localparam int unsigned COL_W  = WORD_WIDTH * STEP_RANGE;
    localparam int unsigned WCNT_W = (STEP_RANGE > 1) ? $clog2(STEP_RANGE) : 1;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    logic [WCNT_W-1:0]     wcnt_q;
    logic [CIDX_WIDTH-1:0] ccnt_q;
    logic [COL_W-1:0]      asm_q;

    logic [COL_W-1:0]      mem_col  [FIFO_DEPTH];
    logic [CIDX_WIDTH-1:0] mem_idx  [FIFO_DEPTH];
    logic                  mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr_q;
    logic [PTR_W-1:0]      rptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [15:0]           frames_q;

    logic             accept;
    logic             push;
    logic             pop;
    logic             frame_end;
    logic [COL_W-1:0] asm_word;

    // Explicit compare-and-reset so non-power-of-2 depths wrap correctly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        in_ready  = (count_q != CNT_W'(FIFO_DEPTH));
        accept    = in_valid && in_ready;
        push      = accept && ((wcnt_q == WCNT_W'(STEP_RANGE - 1)) || in_last);
        frame_end = in_last || (ccnt_q == CIDX_WIDTH'(MAX_LIFM_RSIZ - 1));
        enable_out = (count_q != '0);
        pop       = enable_out && out_ready;
        // Assembly with the incoming word merged in; slots above wcnt are still zero.
        asm_word  = asm_q;
        asm_word[wcnt_q*WORD_WIDTH +: WORD_WIDTH] = in_word;
    end

    always_comb begin
        lifm_column = '0;
        col_idx     = '0;
        col_last    = 1'b0;
        if (enable_out) begin
            lifm_column = mem_col[rptr_q];
            col_idx     = mem_idx[rptr_q];
            col_last    = mem_last[rptr_q];
        end
        frames_done = frames_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt_q   <= '0;
            ccnt_q   <= '0;
            asm_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            frames_q <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_col[i]  <= '0;
                mem_idx[i]  <= '0;
                mem_last[i] <= 1'b0;
            end
        end else begin
            if (accept) begin
                if (push) begin
                    asm_q  <= '0;
                    wcnt_q <= '0;
                    ccnt_q <= frame_end ? '0 : ccnt_q + CIDX_WIDTH'(1);
                end else begin
                    asm_q  <= asm_word;
                    wcnt_q <= wcnt_q + WCNT_W'(1);
                end
            end

            if (push) begin
                mem_col[wptr_q]  <= asm_word;
                mem_idx[wptr_q]  <= ccnt_q;
                mem_last[wptr_q] <= frame_end;
                wptr_q           <= ptr_inc(wptr_q);
            end

            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
                if (mem_last[rptr_q]) begin
                    frames_q <= frames_q + 16'd1;
                end
            end

            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_lifm_column_packer.sv
// Directed testbench for lifm_column_packer with STEP_RANGE=4, WORD_WIDTH=8,
// MAX_LIFM_RSIZ=3, FIFO_DEPTH=2. Inputs change on the falling edge; popped columns are
// recorded 2 ns after the falling edge, well clear of the rising edge.
module tb_lifm_column_packer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_word = 8'h00;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic        enable_out;
    logic [31:0] lifm_column;
    logic [1:0]  col_idx;
    logic        col_last;
    logic [15:0] frames_done;

    int n_checks = 0;
    int n_pass   = 0;

    // Popped columns as {col_last, col_idx, lifm_column}.
    logic [34:0] got_q[$];

    lifm_column_packer #(
        .WORD_WIDTH    (8),
        .STEP_RANGE    (4),
        .MAX_LIFM_RSIZ (3),
        .FIFO_DEPTH    (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_word     (in_word),
        .in_last     (in_last),
        .out_ready   (out_ready),
        .enable_out  (enable_out),
        .lifm_column (lifm_column),
        .col_idx     (col_idx),
        .col_last    (col_last),
        .frames_done (frames_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        #2;
        if (reset_n && enable_out && out_ready) begin
            got_q.push_back({col_last, col_idx, lifm_column});
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] mk(input logic [31:0] col, input logic [1:0] idx,
                                       input logic last);
        return {last, idx, col};
    endfunction

    task automatic check_col(input int i, input string tag, input logic [34:0] exp);
        logic [34:0] got;
        got = (i < got_q.size()) ? got_q[i] : 35'h0;
        check(tag, {29'h0, got}, {29'h0, exp});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        idle(2);
        reset_n = 1'b1;
        got_q.delete();
        @(negedge clk);
    endtask

    // Called on a falling edge; returns on the falling edge after the accepting rising edge.
    task automatic send(input logic [7:0] w, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_word  = w;
        in_last  = l;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("send_timeout", {63'h0, in_ready}, 64'h1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_t1_cols(input int base, input string tag);
        check_col(base + 0, {tag, "_c0"}, mk(32'h04030201, 2'd0, 1'b0));
        check_col(base + 1, {tag, "_c1"}, mk(32'h08070605, 2'd1, 1'b0));
        check_col(base + 2, {tag, "_c2"}, mk(32'h0C0B0A09, 2'd2, 1'b1));
    endtask

    initial begin
        // Reset state
        idle(2);
        check("rst_enable", {63'h0, enable_out}, 64'h0);
        check("rst_column", {32'h0, lifm_column}, 64'h0);
        check("rst_idx_last", {61'h0, col_idx, col_last}, 64'h0);
        check("rst_frames", {48'h0, frames_done}, 64'h0);
        do_reset();
        check("rst_in_ready", {63'h0, in_ready}, 64'h1);

        // T1: 12 words back to back, frame closes implicitly after 3 columns
        out_ready = 1'b1;
        for (int w = 1; w <= 12; w++) begin
            send(8'(w), 1'b0);
            if (w == 3) check("t1_en_early", {63'h0, enable_out}, 64'h0);
            if (w == 4) begin
                check("t1_en_latency", {63'h0, enable_out}, 64'h1);
                check("t1_head", {32'h0, lifm_column}, 64'h04030201);
            end
        end
        idle(4);
        check("t1_count", 64'(got_q.size()), 64'd3);
        check_t1_cols(0, "t1");
        check("t1_frames", {48'h0, frames_done}, 64'd1);

        // T2: in_last on word 6, then word 7 opens a new frame
        do_reset();
        out_ready = 1'b1;
        for (int w = 1; w <= 10; w++) send(8'(w), (w == 6));
        idle(4);
        check("t2_count", 64'(got_q.size()), 64'd3);
        check_col(0, "t2_c0", mk(32'h04030201, 2'd0, 1'b0));
        check_col(1, "t2_c1", mk(32'h00000605, 2'd1, 1'b1));
        check_col(2, "t2_c2", mk(32'h0A090807, 2'd0, 1'b0));
        check("t2_frames", {48'h0, frames_done}, 64'd1);

        // T3: back-pressure fills the FIFO, then drains in order
        do_reset();
        out_ready = 1'b0;
        for (int w = 1; w <= 8; w++) send(8'(w), 1'b0);
        in_valid = 1'b1;
        in_word  = 8'h09;
        idle(3);
        check("t3_in_ready", {63'h0, in_ready}, 64'h0);
        check("t3_enable", {63'h0, enable_out}, 64'h1);
        check("t3_head_hold", {32'h0, lifm_column}, 64'h04030201);
        check("t3_no_pop", 64'(got_q.size()), 64'd0);
        out_ready = 1'b1;
        for (int w = 9; w <= 12; w++) send(8'(w), 1'b0);
        idle(5);
        check("t3_count", 64'(got_q.size()), 64'd3);
        check_t1_cols(0, "t3");
        check("t3_frames", {48'h0, frames_done}, 64'd1);

        // T4: push and pop on the same edge with one column buffered
        do_reset();
        out_ready = 1'b0;
        for (int w = 1; w <= 7; w++) send(8'(w), 1'b0);
        out_ready = 1'b1;
        send(8'h08, 1'b0);
        check("t4_enable", {63'h0, enable_out}, 64'h1);
        check("t4_head", {32'h0, lifm_column}, 64'h08070605);
        check("t4_idx", {62'h0, col_idx}, 64'd1);
        check("t4_in_ready", {63'h0, in_ready}, 64'h1);
        idle(3);
        check("t4_count", 64'(got_q.size()), 64'd2);
        check_col(0, "t4_c0", mk(32'h04030201, 2'd0, 1'b0));
        check_col(1, "t4_c1", mk(32'h08070605, 2'd1, 1'b0));

        // T5: reset mid-column discards the partial column
        do_reset();
        out_ready = 1'b1;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        reset_n = 1'b0;
        #1;
        check("t5_rst_enable", {63'h0, enable_out}, 64'h0);
        check("t5_rst_column", {32'h0, lifm_column}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        got_q.delete();
        @(negedge clk);
        for (int w = 0; w < 4; w++) send(8'hA1 + 8'(w), 1'b0);
        idle(3);
        check("t5_count", 64'(got_q.size()), 64'd1);
        check_col(0, "t5_c0", mk(32'hA4A3A2A1, 2'd0, 1'b0));

        // T6: in_valid toggling, two frames, then frames_done wrap
        do_reset();
        out_ready = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int w = 1; w <= 12; w++) begin
                send(8'(w), 1'b0);
                idle(1);
            end
        end
        idle(3);
        check("t6_count", 64'(got_q.size()), 64'd6);
        check_t1_cols(0, "t6a");
        check_t1_cols(3, "t6b");
        check("t6_frames", {48'h0, frames_done}, 64'd2);

        force dut.frames_q = 16'hFFFE;
        @(negedge clk);
        release dut.frames_q;
        @(negedge clk);
        check("t6_preload", {48'h0, frames_done}, 64'hFFFE);
        send(8'h55, 1'b1);
        idle(1);
        check("t6_ffff", {48'h0, frames_done}, 64'hFFFF);
        send(8'h66, 1'b1);
        idle(2);
        check("t6_wrap", {48'h0, frames_done}, 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
